// File: rtl/puf_crp_sequencer.sv
// Challenge/response sequencer for an arbiter PUF: LFSR challenges, ARM/FIRE race pulse,
// synchronised response capture and valid/ready hand-off of N_RESP-bit words.
module puf_crp_sequencer #(
    parameter int C_LENGTH = 8,
    parameter int N_RESP   = 8,
    parameter int SETTLE   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                istart,
    input  logic                ireseed,
    input  logic [C_LENGTH-1:0] iseed,
    output logic [C_LENGTH-1:0] ochallenge,
    output logic                opulse,
    input  logic                iresponse,
    output logic [N_RESP-1:0]   oword,
    output logic                ovalid,
    input  logic                iready,
    output logic                obusy
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_FIRE, S_SAMPLE, S_OUT} state_t;

    localparam int CW = $clog2(SETTLE + 2);
    localparam int BW = $clog2(N_RESP + 1);
    localparam logic [CW-1:0] PH_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0] SMP_LAST = CW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N_RESP - 1);
    localparam logic [C_LENGTH-1:0] ONE = C_LENGTH'(1);

    // Maximal-length Fibonacci tap masks, bit i set means c[i] feeds the XOR.
    function automatic logic [31:0] tap_mask(input int n);
        case (n)
            4:       tap_mask = 32'h0000_000C;
            5:       tap_mask = 32'h0000_0014;
            6:       tap_mask = 32'h0000_0030;
            7:       tap_mask = 32'h0000_0060;
            8:       tap_mask = 32'h0000_00B8;
            9:       tap_mask = 32'h0000_0110;
            10:      tap_mask = 32'h0000_0240;
            12:      tap_mask = 32'h0000_0829;
            16:      tap_mask = 32'h0000_D008;
            default: tap_mask = (32'd1 << (n - 1)) | (32'd1 << (n - 2));
        endcase
    endfunction

    localparam logic [31:0]         TAPS  = tap_mask(C_LENGTH);
    localparam logic [C_LENGTH-1:0] TAP_V = TAPS[C_LENGTH-1:0];

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [BW-1:0]       r_bit;
    logic [1:0]          r_sync;
    logic [C_LENGTH-1:0] r_chal;
    logic [N_RESP-1:0]   r_word;
    logic                r_pulse, r_valid;

    logic                w_load, w_shift, w_phase_end, w_fb;
    logic [C_LENGTH-1:0] w_seed, w_lfsr_nxt;

    assign w_fb       = ^(r_chal & TAP_V);
    assign w_lfsr_nxt = {r_chal[C_LENGTH-2:0], w_fb};
    assign w_seed     = (iseed == '0) ? ONE : iseed;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_phase_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (istart) begin
                    w_state_nxt = S_ARM;
                    w_load      = ireseed;
                end
            end
            S_ARM: begin
                if (r_cnt == PH_LAST) begin
                    w_state_nxt = S_FIRE;
                    w_phase_end = 1'b1;
                end
            end
            S_FIRE: begin
                if (r_cnt == PH_LAST) begin
                    w_state_nxt = S_SAMPLE;
                    w_phase_end = 1'b1;
                end
            end
            S_SAMPLE: begin
                // Two extra cycles let the response clear the synchroniser.
                if (r_cnt == SMP_LAST) begin
                    w_phase_end = 1'b1;
                    w_shift     = 1'b1;
                    w_state_nxt = (r_bit == BIT_LAST) ? S_OUT : S_ARM;
                end
            end
            S_OUT: begin
                if (iready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_chal  <= ONE;
            r_word  <= '0;
            r_pulse <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], iresponse};
            r_pulse <= (w_state_nxt == S_FIRE) || (w_state_nxt == S_SAMPLE);
            r_valid <= (w_state_nxt == S_OUT);
            if (w_phase_end || r_state == S_IDLE || r_state == S_OUT) r_cnt <= '0;
            else                                                      r_cnt <= r_cnt + CW'(1);
            if (w_load)       r_chal <= w_seed;
            else if (w_shift) r_chal <= w_lfsr_nxt;
            if (w_shift) begin
                r_word <= {r_word[N_RESP-2:0], r_sync[1]};
                r_bit  <= (r_bit == BIT_LAST) ? '0 : r_bit + BW'(1);
            end
        end
    end

    assign ochallenge = r_chal;
    assign opulse     = r_pulse;
    assign oword      = r_word;
    assign ovalid     = r_valid;
    assign obusy      = (r_state != S_IDLE);

endmodule
